lc3_decode: RTL and testbench
=============================

// Module: lc3_decode
// PURPOSE
//  LC3 decode stage, directly downstream of fetch. Latches the fetched instruction (imem dout) with its
//  pc/npc into a one-entry pipeline register. Produces registered execute/writeback/memory control fields.
//  Uses a valid/ready handshake with fetch and execute, and supports a synchronous flush on a taken branch.
// PARAMETERS
//  AW      16   address width of pc/npc
//  IW      16   instruction width (LC3 fixed; exposed for checking only)
// PORTS
//  clk          in   1   rising-edge clock
//  rst          in   1   asynchronous, active-high reset
//  f_valid      in   1   fetch presents a valid instruction this cycle
//  f_ready      out  1   decode can accept (comb: !d_valid | e_ready)
//  f_pc         in   AW  pc of presented instruction
//  f_npc        in   AW  pc+1 of presented instruction
//  dout         in   IW  instruction word from imem
//  flush        in   1   br_taken from execute; kill held and incoming instruction
//  e_ready      in   1   execute accepts d_valid output this cycle
//  d_valid      out  1   ir/controls valid
//  ir           out  IW  latched instruction
//  pc_out       out  AW  latched pc
//  npc_out      out  AW  latched npc
//  e_control    out  6   {alu_op[1:0], imm_sel, pcoff_sel[1:0], base_sel}
//  w_control    out  2   00 none, 01 ALU, 10 MEM, 11 PC-relative (LEA)
//  mem_control  out  3   {ind, st, ld}
//  br_en        out  1   instruction is BR/JMP
// BEHAVIOUR
//  - Reset: d_valid=0; ir, pc_out, npc_out, all control outputs=0. Async assert, sync release.
//  - Accept = f_valid & f_ready. Drain = d_valid & e_ready. Latency is 1 clk from accept to d_valid.
//  - Edge priority: flush > accept > drain. On flush: d_valid<=0; incoming word dropped; data regs hold.
//  - Otherwise, on accept: load ir/pc/npc and decoded controls; set d_valid<=1.
//    On drain without accept: d_valid<=0. Otherwise hold (stall: all outputs stable).
//  - f_ready is combinational and independent of flush; fetch must treat a flushed cycle as consumed.
//  - Controls are decoded from dout at accept and registered. They never change while d_valid & !e_ready.
//  - alu_op: 00 ADD, 01 AND, 10 NOT, 11 pass. pcoff_sel: 00 zero, 01 off9, 10 off6, 11 off11.
//  - base_sel: 1=PC, 0=BaseR. imm_sel=ir[5] for ADD/AND, else 0.
//  - Opcode table:
//    ADD/AND: alu 00/01, w=01. NOT: alu 10, w=01.
//    LD/LDR/LDI: ld=1, w=10. Offsets/bases off9+PC, off6+BaseR, and off9+PC with ind=1.
//    ST/STR/STI: st=1, w=00. Same offset/base rules as the loads.
//    LEA: w=11, off9+PC. BR: br_en, off9+PC. JMP: br_en, zero+BaseR.
//  - Unsupported opcodes (JSR 0100, RTI 1000, rsvd 1101, TRAP 1111) decode to all-zero controls (NOP).
//  - A flush asserted together with rst has no extra effect; reset dominates.
// CONFIGURATION
//  - LC3_DECODE_ILLEGAL_EN defined: adds output port illegal (1 bit, reset 0). It is registered with the
//    controls and set for the unsupported opcodes. It is cleared by flush and drain like d_valid.
//  - Not defined: port absent; unsupported opcodes are silent NOPs.
// STRUCTURE
//  - Shared package lc3_pkg holds: opcode localparams (OP_ADD..OP_TRAP), ALU_* encodings, W_* encodings,
//    PCOFF_* encodings, and the field widths of e/w/mem_control.
//  - Sub-module lc3_ctrl_dec is a purely combinational opcode -> {e,w,mem,br_en[,illegal]} decoder.
//    lc3_decode keeps only the handshake and the pipeline register.
// TESTING
//  - Reset: assert rst mid-cycle with d_valid=1 -> d_valid, ir and controls go to 0 immediately (async).
//  - Accept: dout=16'h1262 (ADD R1,R1,#2), f_pc=16'h3000, f_npc=16'h3001, e_ready=1.
//    Next cycle -> ir=1262, e_control[5:4]=00, imm_sel=1, w_control=01, d_valid=1.
//  - Stall: LDR 16'h6443 accepted, e_ready=0 for 3 clks -> outputs hold.
//    ld=1, pcoff_sel=10, base_sel=0, and f_ready=0 throughout.
//  - Flush: d_valid=1 and f_valid=1 with flush=1 -> next cycle d_valid=0 and the incoming word is not loaded.
//  - Back-to-back: e_ready=1 with 4 consecutive words (LEA 16'hE002, BR 16'h0FFE, STI 16'hB1FF, JMP 16'hC1C0)
//    -> one output per clk. Controls: w=11; br_en=1; {ind,st,ld}=110; br_en=1 with base_sel=0.
//  - With LC3_DECODE_ILLEGAL_EN: dout=16'hD000 -> illegal=1 and all controls 0. Without the macro: NOP, no port.

Source files
------------

// File: rtl/lc3_pkg.sv
// ============================================================================
// Module : lc3_pkg
// Brief  : Shared definitions for the LC3 decode stage: opcode values,
//          ALU / writeback / pc-offset field encodings and control widths.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lc3_pkg;

    // Opcodes (instruction bits [15:12])
    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RSVD = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    // ALU operation
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_AND  = 2'b01;
    localparam logic [1:0] ALU_NOT  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    // Writeback source
    localparam logic [1:0] W_NONE = 2'b00;
    localparam logic [1:0] W_ALU  = 2'b01;
    localparam logic [1:0] W_MEM  = 2'b10;
    localparam logic [1:0] W_PC   = 2'b11;

    // PC/base offset selection
    localparam logic [1:0] PCOFF_ZERO  = 2'b00;
    localparam logic [1:0] PCOFF_OFF9  = 2'b01;
    localparam logic [1:0] PCOFF_OFF6  = 2'b10;
    localparam logic [1:0] PCOFF_OFF11 = 2'b11;

    // Control field widths
    localparam int E_CTRL_W   = 6;  // {alu_op[1:0], imm_sel, pcoff_sel[1:0], base_sel}
    localparam int W_CTRL_W   = 2;
    localparam int MEM_CTRL_W = 3;  // {ind, st, ld}

endpackage

`default_nettype wire

// File: rtl/lc3_ctrl_dec.sv
// ============================================================================
// Module : lc3_ctrl_dec
// Brief  : Purely combinational LC3 opcode -> control-field decoder.
// Ports  : opcode_i      instruction bits [15:12]
//          imm_flag_i    instruction bit [5] (immediate form of ADD/AND)
//          e_control_o   {alu_op[1:0], imm_sel, pcoff_sel[1:0], base_sel}
//          w_control_o   writeback source
//          mem_control_o {ind, st, ld}
//          br_en_o       BR / JMP
//          illegal_o     unsupported opcode (only with LC3_DECODE_ILLEGAL_EN)
// Config : LC3_DECODE_ILLEGAL_EN adds illegal_o.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lc3_ctrl_dec
    import lc3_pkg::*;
(
    input  logic [3:0]            opcode_i,
    input  logic                  imm_flag_i,
    output logic [E_CTRL_W-1:0]   e_control_o,
    output logic [W_CTRL_W-1:0]   w_control_o,
    output logic [MEM_CTRL_W-1:0] mem_control_o,
`ifdef LC3_DECODE_ILLEGAL_EN
    output logic                  br_en_o,
    output logic                  illegal_o
`else
    output logic                  br_en_o
`endif
);

    logic [1:0] w_alu_op;
    logic       w_imm_sel;
    logic [1:0] w_pcoff_sel;
    logic       w_base_sel;
    logic [1:0] w_wsel;
    logic       w_ind;
    logic       w_st;
    logic       w_ld;
    logic       w_br;
`ifdef LC3_DECODE_ILLEGAL_EN
    logic       w_illegal;
`endif

    always_comb begin
        w_alu_op    = ALU_ADD;
        w_imm_sel   = 1'b0;
        w_pcoff_sel = PCOFF_ZERO;
        w_base_sel  = 1'b0;
        w_wsel      = W_NONE;
        w_ind       = 1'b0;
        w_st        = 1'b0;
        w_ld        = 1'b0;
        w_br        = 1'b0;
`ifdef LC3_DECODE_ILLEGAL_EN
        w_illegal   = 1'b0;
`endif
        case (opcode_i)
            OP_ADD: begin
                w_imm_sel = imm_flag_i;
                w_wsel    = W_ALU;
            end
            OP_AND: begin
                w_alu_op  = ALU_AND;
                w_imm_sel = imm_flag_i;
                w_wsel    = W_ALU;
            end
            OP_NOT: begin
                w_alu_op  = ALU_NOT;
                w_wsel    = W_ALU;
            end
            OP_LD: begin
                w_ld        = 1'b1;
                w_wsel      = W_MEM;
                w_pcoff_sel = PCOFF_OFF9;
                w_base_sel  = 1'b1;
            end
            OP_LDR: begin
                w_ld        = 1'b1;
                w_wsel      = W_MEM;
                w_pcoff_sel = PCOFF_OFF6;
            end
            OP_LDI: begin
                w_ld        = 1'b1;
                w_ind       = 1'b1;
                w_wsel      = W_MEM;
                w_pcoff_sel = PCOFF_OFF9;
                w_base_sel  = 1'b1;
            end
            OP_ST: begin
                w_st        = 1'b1;
                w_pcoff_sel = PCOFF_OFF9;
                w_base_sel  = 1'b1;
            end
            OP_STR: begin
                w_st        = 1'b1;
                w_pcoff_sel = PCOFF_OFF6;
            end
            OP_STI: begin
                w_st        = 1'b1;
                w_ind       = 1'b1;
                w_pcoff_sel = PCOFF_OFF9;
                w_base_sel  = 1'b1;
            end
            OP_LEA: begin
                w_wsel      = W_PC;
                w_pcoff_sel = PCOFF_OFF9;
                w_base_sel  = 1'b1;
            end
            OP_BR: begin
                w_br        = 1'b1;
                w_pcoff_sel = PCOFF_OFF9;
                w_base_sel  = 1'b1;
            end
            OP_JMP: begin
                w_br        = 1'b1;
            end
            default: begin
                // JSR, RTI, reserved, TRAP: all controls stay zero (NOP)
`ifdef LC3_DECODE_ILLEGAL_EN
                w_illegal = 1'b1;
`endif
            end
        endcase
    end

    assign e_control_o   = {w_alu_op, w_imm_sel, w_pcoff_sel, w_base_sel};
    assign w_control_o   = w_wsel;
    assign mem_control_o = {w_ind, w_st, w_ld};
    assign br_en_o       = w_br;
`ifdef LC3_DECODE_ILLEGAL_EN
    assign illegal_o     = w_illegal;
`endif

endmodule

`default_nettype wire

// File: rtl/lc3_decode.sv
// ============================================================================
// Module : lc3_decode
// Brief  : LC3 decode stage. One-entry pipeline register between fetch and
//          execute holding ir/pc/npc plus registered control fields, with a
//          valid/ready handshake on both sides and a synchronous flush.
// Ports  : clk, rst (async, active-high)
//          f_valid/f_ready/f_pc/f_npc/dout   fetch side
//          flush                              taken branch from execute
//          e_ready/d_valid/ir/pc_out/npc_out  execute side
//          e_control/w_control/mem_control/br_en   registered controls
//          illegal                            only with LC3_DECODE_ILLEGAL_EN
// Config : LC3_DECODE_ILLEGAL_EN adds the illegal output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lc3_decode
    import lc3_pkg::*;
#(
    parameter int AW = 16,
    parameter int IW = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  f_valid,
    output logic                  f_ready,
    input  logic [AW-1:0]         f_pc,
    input  logic [AW-1:0]         f_npc,
    input  logic [IW-1:0]         dout,
    input  logic                  flush,
    input  logic                  e_ready,
    output logic                  d_valid,
    output logic [IW-1:0]         ir,
    output logic [AW-1:0]         pc_out,
    output logic [AW-1:0]         npc_out,
    output logic [E_CTRL_W-1:0]   e_control,
    output logic [W_CTRL_W-1:0]   w_control,
    output logic [MEM_CTRL_W-1:0] mem_control,
`ifdef LC3_DECODE_ILLEGAL_EN
    output logic                  br_en,
    output logic                  illegal
`else
    output logic                  br_en
`endif
);

    logic                  w_accept;
    logic                  w_drain;
    logic                  d_valid_d;
    logic                  d_valid_q;
    logic [IW-1:0]         ir_q;
    logic [AW-1:0]         pc_q;
    logic [AW-1:0]         npc_q;
    logic [E_CTRL_W-1:0]   e_ctrl_q;
    logic [W_CTRL_W-1:0]   w_ctrl_q;
    logic [MEM_CTRL_W-1:0] mem_ctrl_q;
    logic                  br_en_q;
    logic [E_CTRL_W-1:0]   w_dec_e;
    logic [W_CTRL_W-1:0]   w_dec_w;
    logic [MEM_CTRL_W-1:0] w_dec_mem;
    logic                  w_dec_br;
`ifdef LC3_DECODE_ILLEGAL_EN
    logic                  w_dec_illegal;
    logic                  illegal_d;
    logic                  illegal_q;
`endif

    lc3_ctrl_dec u_ctrl_dec (
        .opcode_i      (dout[IW-1 -: 4]),
        .imm_flag_i    (dout[5]),
        .e_control_o   (w_dec_e),
        .w_control_o   (w_dec_w),
        .mem_control_o (w_dec_mem),
`ifdef LC3_DECODE_ILLEGAL_EN
        .br_en_o       (w_dec_br),
        .illegal_o     (w_dec_illegal)
`else
        .br_en_o       (w_dec_br)
`endif
    );

    // Ready does not look at flush: a flushed cycle still counts as consumed
    // from fetch's point of view.
    assign f_ready  = !d_valid_q || e_ready;
    assign w_accept = f_valid && f_ready;
    assign w_drain  = d_valid_q && e_ready;

    // Priority: flush > accept > drain > hold
    always_comb begin
        d_valid_d = d_valid_q;
        if (flush) begin
            d_valid_d = 1'b0;
        end else if (w_accept) begin
            d_valid_d = 1'b1;
        end else if (w_drain) begin
            d_valid_d = 1'b0;
        end
    end

`ifdef LC3_DECODE_ILLEGAL_EN
    // illegal tracks d_valid: cleared by flush/drain, loaded on accept
    always_comb begin
        illegal_d = illegal_q;
        if (flush) begin
            illegal_d = 1'b0;
        end else if (w_accept) begin
            illegal_d = w_dec_illegal;
        end else if (w_drain) begin
            illegal_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_valid_q  <= 1'b0;
            ir_q       <= '0;
            pc_q       <= '0;
            npc_q      <= '0;
            e_ctrl_q   <= '0;
            w_ctrl_q   <= '0;
            mem_ctrl_q <= '0;
            br_en_q    <= 1'b0;
        end else begin
            d_valid_q <= d_valid_d;
            // Data and controls only move on a real accept; flush and drain
            // leave them as they were.
            if (!flush && w_accept) begin
                ir_q       <= dout;
                pc_q       <= f_pc;
                npc_q      <= f_npc;
                e_ctrl_q   <= w_dec_e;
                w_ctrl_q   <= w_dec_w;
                mem_ctrl_q <= w_dec_mem;
                br_en_q    <= w_dec_br;
            end
        end
    end

    assign d_valid     = d_valid_q;
    assign ir          = ir_q;
    assign pc_out      = pc_q;
    assign npc_out     = npc_q;
    assign e_control   = e_ctrl_q;
    assign w_control   = w_ctrl_q;
    assign mem_control = mem_ctrl_q;
    assign br_en       = br_en_q;

endmodule

`default_nettype wire

// File: tb/tb_lc3_decode.sv
// ============================================================================
// Module : tb_lc3_decode
// Brief  : Self-checking bench for lc3_decode: directed vector table,
//          hand-written stall/flush/reset sequences, and randomized traffic
//          against a behavioural model.
// Config : honours LC3_DECODE_ILLEGAL_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lc3_decode;

    logic        clk;
    logic        rst;
    logic        f_valid;
    logic        f_ready;
    logic [15:0] f_pc;
    logic [15:0] f_npc;
    logic [15:0] dout;
    logic        flush;
    logic        e_ready;
    logic        d_valid;
    logic [15:0] ir;
    logic [15:0] pc_out;
    logic [15:0] npc_out;
    logic [5:0]  e_control;
    logic [1:0]  w_control;
    logic [2:0]  mem_control;
    logic        br_en;
`ifdef LC3_DECODE_ILLEGAL_EN
    logic        illegal;
`endif

    int total = 0;
    int bad   = 0;

    lc3_decode #(.AW(16), .IW(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .f_valid     (f_valid),
        .f_ready     (f_ready),
        .f_pc        (f_pc),
        .f_npc       (f_npc),
        .dout        (dout),
        .flush       (flush),
        .e_ready     (e_ready),
        .d_valid     (d_valid),
        .ir          (ir),
        .pc_out      (pc_out),
        .npc_out     (npc_out),
        .e_control   (e_control),
        .w_control   (w_control),
        .mem_control (mem_control),
`ifdef LC3_DECODE_ILLEGAL_EN
        .br_en       (br_en),
        .illegal     (illegal)
`else
        .br_en       (br_en)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] ins;
        logic [5:0]  e;
        logic [1:0]  w;
        logic [2:0]  m;
        logic        br;
        logic        il;
    } vec_t;

    vec_t vec [17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference decode, from the opcode table expressed as set membership.
    function automatic void ref_dec(input logic [15:0] ins,
                                    output logic [5:0] e, output logic [1:0] w,
                                    output logic [2:0] m, output logic br,
                                    output logic il, output logic [5:0] emask);
        int  o;
        bit  is_alu, legal, pc9, b6, ld, st, ind;
        int  alu, pcoff;
        bit  imm;
        o      = int'(ins[15:12]);
        is_alu = (o == 1) || (o == 5) || (o == 9);
        legal  = !((o == 4) || (o == 8) || (o == 13) || (o == 15));
        pc9    = (o == 0) || (o == 2) || (o == 3) || (o == 10) || (o == 11) || (o == 14);
        b6     = (o == 6) || (o == 7);
        ld     = (o == 2) || (o == 6) || (o == 10);
        st     = (o == 3) || (o == 7) || (o == 11);
        ind    = (o == 10) || (o == 11);
        alu    = (o == 5) ? 1 : (o == 9) ? 2 : 0;
        imm    = ((o == 1) || (o == 5)) && ins[5];
        pcoff  = pc9 ? 1 : b6 ? 2 : 0;
        e      = {2'(alu), imm, 2'(pcoff), pc9};
        w      = is_alu ? 2'd1 : ld ? 2'd2 : (o == 14) ? 2'd3 : 2'd0;
        m      = {ind, st, ld};
        br     = (o == 0) || (o == 12);
        il     = !legal;
        // alu_op is only defined for ALU ops (and must be 0 for NOPs)
        emask  = (is_alu || !legal) ? 6'h3F : 6'h0F;
    endfunction

    // Behavioural model state for the random phase
    logic        mv;
    logic        m_il;
    logic [15:0] m_ir, m_pc, m_npc;

    initial begin
        logic [5:0] re, rmask;
        logic [1:0] rw;
        logic [2:0] rm;
        logic       rbr, ril;
        bit         exp_rdy;

        vec[0]  = '{16'h1262, 6'h08, 2'b01, 3'b000, 1'b0, 1'b0}; // ADD imm
        vec[1]  = '{16'h6443, 6'h04, 2'b10, 3'b001, 1'b0, 1'b0}; // LDR
        vec[2]  = '{16'hE002, 6'h03, 2'b11, 3'b000, 1'b0, 1'b0}; // LEA
        vec[3]  = '{16'h0FFE, 6'h03, 2'b00, 3'b000, 1'b1, 1'b0}; // BR
        vec[4]  = '{16'hB1FF, 6'h03, 2'b00, 3'b110, 1'b0, 1'b0}; // STI
        vec[5]  = '{16'hC1C0, 6'h00, 2'b00, 3'b000, 1'b1, 1'b0}; // JMP
        vec[6]  = '{16'hD000, 6'h00, 2'b00, 3'b000, 1'b0, 1'b1}; // rsvd
        vec[7]  = '{16'h5A3F, 6'h18, 2'b01, 3'b000, 1'b0, 1'b0}; // AND imm
        vec[8]  = '{16'h9A7F, 6'h20, 2'b01, 3'b000, 1'b0, 1'b0}; // NOT
        vec[9]  = '{16'h1001, 6'h00, 2'b01, 3'b000, 1'b0, 1'b0}; // ADD reg
        vec[10] = '{16'h2005, 6'h03, 2'b10, 3'b001, 1'b0, 1'b0}; // LD
        vec[11] = '{16'hA005, 6'h03, 2'b10, 3'b101, 1'b0, 1'b0}; // LDI
        vec[12] = '{16'h3005, 6'h03, 2'b00, 3'b010, 1'b0, 1'b0}; // ST
        vec[13] = '{16'h7045, 6'h04, 2'b00, 3'b010, 1'b0, 1'b0}; // STR
        vec[14] = '{16'h4000, 6'h00, 2'b00, 3'b000, 1'b0, 1'b1}; // JSR
        vec[15] = '{16'h8000, 6'h00, 2'b00, 3'b000, 1'b0, 1'b1}; // RTI
        vec[16] = '{16'hF025, 6'h00, 2'b00, 3'b000, 1'b0, 1'b1}; // TRAP

        rst = 1'b1; f_valid = 1'b0; f_pc = '0; f_npc = '0; dout = '0;
        flush = 1'b0; e_ready = 1'b0;

        // ---------------- reset state ----------------
        #12;
        chk("rst_d_valid", 32'(d_valid), 0);
        chk("rst_ir", 32'(ir), 0);
        chk("rst_pc", 32'(pc_out), 0);
        chk("rst_npc", 32'(npc_out), 0);
        chk("rst_e", 32'(e_control), 0);
        chk("rst_w", 32'(w_control), 0);
        chk("rst_mem", 32'(mem_control), 0);
        chk("rst_br", 32'(br_en), 0);
        chk("rst_f_ready", 32'(f_ready), 1);
`ifdef LC3_DECODE_ILLEGAL_EN
        chk("rst_illegal", 32'(illegal), 0);
`endif
        rst = 1'b0;

        // ---------------- back-to-back table ----------------
        e_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            f_valid = 1'b1;
            dout    = vec[i].ins;
            f_pc    = 16'h3000 + 16'(i);
            f_npc   = 16'h3001 + 16'(i);
            #1;
            chk("tbl_f_ready", 32'(f_ready), 1);
            tick();
            ref_dec(vec[i].ins, re, rw, rm, rbr, ril, rmask);
            chk("tbl_d_valid", 32'(d_valid), 1);
            chk("tbl_ir", 32'(ir), 32'(vec[i].ins));
            chk("tbl_pc", 32'(pc_out), 32'(16'h3000 + 16'(i)));
            chk("tbl_npc", 32'(npc_out), 32'(16'h3001 + 16'(i)));
            chk("tbl_e", 32'(e_control & rmask), 32'(vec[i].e & rmask));
            chk("tbl_w", 32'(w_control), 32'(vec[i].w));
            chk("tbl_mem", 32'(mem_control), 32'(vec[i].m));
            chk("tbl_br", 32'(br_en), 32'(vec[i].br));
`ifdef LC3_DECODE_ILLEGAL_EN
            chk("tbl_illegal", 32'(illegal), 32'(vec[i].il));
`endif
        end
        f_valid = 1'b0;
        tick();
        chk("drain_d_valid", 32'(d_valid), 0);
`ifdef LC3_DECODE_ILLEGAL_EN
        chk("drain_illegal", 32'(illegal), 0);
`endif

        // ---------------- stall ----------------
        f_valid = 1'b1; dout = 16'h6443; f_pc = 16'h4000; f_npc = 16'h4001; e_ready = 1'b0;
        tick();
        dout = 16'h1262; f_pc = 16'h5000; f_npc = 16'h5001;
        for (int k = 0; k < 3; k++) begin
            chk("stall_f_ready", 32'(f_ready), 0);
            tick();
            chk("stall_d_valid", 32'(d_valid), 1);
            chk("stall_ir", 32'(ir), 32'h6443);
            chk("stall_pc", 32'(pc_out), 32'h4000);
            chk("stall_e", 32'(e_control), 32'h04);
            chk("stall_mem", 32'(mem_control), 32'h1);
            chk("stall_w", 32'(w_control), 32'h2);
        end
        f_valid = 1'b0; e_ready = 1'b1;
        tick();
        chk("stall_release", 32'(d_valid), 0);

        // ---------------- flush ----------------
        f_valid = 1'b1; dout = 16'h1262; f_pc = 16'h3000; f_npc = 16'h3001; e_ready = 1'b0;
        tick();
        chk("flush_pre_valid", 32'(d_valid), 1);
        dout = 16'hE002; f_pc = 16'h3100; f_npc = 16'h3101; flush = 1'b1; e_ready = 1'b1;
        #1;
        chk("flush_f_ready", 32'(f_ready), 1);
        tick();
        chk("flush_d_valid", 32'(d_valid), 0);
        chk("flush_ir_hold", 32'(ir), 32'h1262);
        chk("flush_pc_hold", 32'(pc_out), 32'h3000);
        chk("flush_w_hold", 32'(w_control), 32'h1);
        flush = 1'b0; f_valid = 1'b0;

`ifdef LC3_DECODE_ILLEGAL_EN
        // ---------------- illegal ----------------
        f_valid = 1'b1; dout = 16'hD000; e_ready = 1'b1;
        tick();
        chk("ill_set", 32'(illegal), 1);
        chk("ill_e", 32'(e_control), 0);
        chk("ill_w", 32'(w_control), 0);
        chk("ill_mem", 32'(mem_control), 0);
        f_valid = 1'b0;
        tick();
        chk("ill_clear", 32'(illegal), 0);
`endif

        // ---------------- async reset ----------------
        f_valid = 1'b1; dout = 16'h1262; f_pc = 16'h3000; f_npc = 16'h3001; e_ready = 1'b0;
        tick();
        f_valid = 1'b0;
        chk("arst_pre_valid", 32'(d_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_d_valid", 32'(d_valid), 0);
        chk("arst_ir", 32'(ir), 0);
        chk("arst_pc", 32'(pc_out), 0);
        chk("arst_e", 32'(e_control), 0);
        chk("arst_w", 32'(w_control), 0);
        #2 rst = 1'b0;
        tick();

        // ---------------- random traffic vs model ----------------
        mv = 1'b0; m_il = 1'b0; m_ir = '0; m_pc = '0; m_npc = '0;
        for (int c = 0; c < 600; c++) begin
            f_valid = ($urandom_range(3) != 0);
            e_ready = ($urandom_range(1) != 0);
            flush   = ($urandom_range(7) == 0);
            dout    = 16'($urandom);
            f_pc    = 16'($urandom);
            f_npc   = f_pc + 16'd1;
            #1;
            exp_rdy = !mv || e_ready;
            chk("rnd_f_ready", 32'(f_ready), 32'(exp_rdy));
            if (flush) begin
                mv = 1'b0; m_il = 1'b0;
            end else if (f_valid && exp_rdy) begin
                mv = 1'b1; m_ir = dout; m_pc = f_pc; m_npc = f_npc;
                ref_dec(dout, re, rw, rm, rbr, ril, rmask);
                m_il = ril;
            end else if (mv && e_ready) begin
                mv = 1'b0; m_il = 1'b0;
            end
            tick();
            chk("rnd_d_valid", 32'(d_valid), 32'(mv));
            chk("rnd_ir", 32'(ir), 32'(m_ir));
            chk("rnd_pc", 32'(pc_out), 32'(m_pc));
            chk("rnd_npc", 32'(npc_out), 32'(m_npc));
            if (mv) begin
                ref_dec(m_ir, re, rw, rm, rbr, ril, rmask);
                chk("rnd_e", 32'(e_control & rmask), 32'(re & rmask));
                chk("rnd_w", 32'(w_control), 32'(rw));
                chk("rnd_mem", 32'(mem_control), 32'(rm));
                chk("rnd_br", 32'(br_en), 32'(rbr));
            end
`ifdef LC3_DECODE_ILLEGAL_EN
            chk("rnd_illegal", 32'(illegal), 32'(m_il));
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
